cal_pulse_gen: RTL and testbench

- Transmit-side calibration pulse generator for the DCFEB.
- On a single-cycle START it drives a programmable train of injection or external calibration pulses toward the skew-clear/LV pulse lines.
- Each pulse has a programmable delay, width, period and count.
- Keeps 12-bit sent-pulse counters that software compares against the receive-side INJ/EXT pulse counters for loopback checks.

---
 rtl/cal_pkg.sv | 19 +
 rtl/cal_vote3.sv | 13 +
 rtl/cal_pulse_gen.sv | 164 ++++++++++++++++
 tb/tb_cal_pulse_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared definitions for the DCFEB calibration pulse generator.
// FSM encoding, default field widths and pulse-line select codes.
`timescale 1ns/1ps
package cal_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int DLY_W = 8;
    localparam int WID_W = 4;
    localparam int PER_W = 12;
    localparam int CNT_W = 12;

    localparam logic INJ_SEL = 1'b0;
    localparam logic EXT_SEL = 1'b1;
endpackage

// File: rtl/cal_vote3.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
// Purely combinational, no latency, no flow control.
`timescale 1ns/1ps
module cal_vote3 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/cal_pulse_gen.sv
// Calibration pulse-train generator: delay, then NPULSE pulses of Weff high / Peff period.
// First leading edge lands DELAY+1 cycles after START; START is ignored while busy.
`timescale 1ns/1ps
module cal_pulse_gen #(
    parameter int TMR   = 0,
    parameter int DLY_W = cal_pkg::DLY_W,
    parameter int WID_W = cal_pkg::WID_W,
    parameter int PER_W = cal_pkg::PER_W
) (
    input  logic             CLK40,
    input  logic             RST_RESYNC,
    input  logic             START,
    input  logic             ABORT,
    input  logic             SEL,
    input  logic [DLY_W-1:0] DELAY,
    input  logic [WID_W-1:0] WIDTH,
    input  logic [PER_W-1:0] PERIOD,
    input  logic [7:0]       NPULSE,
    output logic             INJ_OUT,
    output logic             EXT_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [11:0]      INJ_SENT,
    output logic [11:0]      EXT_SENT
);
    import cal_pkg::*;

    localparam int DC_A = (DLY_W > PER_W) ? DLY_W : PER_W;
    localparam int DC_W = (DC_A > WID_W) ? DC_A : WID_W;

    // Everything that feeds back on itself lives here so it can be triplicated as one unit.
    typedef struct packed {
        state_t           st;
        logic [DC_W-1:0]  cnt;
        logic [7:0]       idx;
        logic [CNT_W-1:0] inj_sent;
        logic [CNT_W-1:0] ext_sent;
    } core_t;
    localparam int CORE_W = $bits(core_t);

    core_t           cur;
    core_t           nxt;
    logic            done_nxt;
    logic            cfg_ld;
    logic            rise;

    logic            sel_q;
    logic [WID_W-1:0] weff_q;
    logic [PER_W:0]  peff_q;
    logic [7:0]      npulse_q;

    logic [WID_W-1:0] weff_in;
    logic [PER_W:0]  peff_min;
    logic [PER_W:0]  peff_in;

    assign weff_in  = (WIDTH == '0) ? WID_W'(1) : WIDTH;
    assign peff_min = (PER_W+1)'(weff_in) + (PER_W+1)'(1);
    assign peff_in  = ({1'b0, PERIOD} < peff_min) ? peff_min : {1'b0, PERIOD};

    always_comb begin
        nxt      = cur;
        done_nxt = 1'b0;
        cfg_ld   = 1'b0;
        rise     = 1'b0;
        case (cur.st)
            IDLE: begin
                if (START && !ABORT) begin
                    nxt.st  = DLY;
                    nxt.cnt = DC_W'(DELAY);
                    nxt.idx = '0;
                    cfg_ld  = 1'b1;
                end
            end
            DLY, LOW: begin
                if (ABORT)               nxt.st  = IDLE;
                else if (cur.cnt == '0)  rise    = 1'b1;
                else                     nxt.cnt = cur.cnt - DC_W'(1);
            end
            HIGH: begin
                if (ABORT) begin
                    nxt.st = IDLE;
                end else if (cur.cnt == '0) begin
                    // NPULSE of zero never matches, so the train runs until ABORT
                    if (npulse_q != 8'd0 && cur.idx == npulse_q) begin
                        nxt.st   = IDLE;
                        done_nxt = 1'b1;
                    end else begin
                        nxt.st  = LOW;
                        nxt.cnt = DC_W'(peff_q - (PER_W+1)'(weff_q) - (PER_W+1)'(1));
                    end
                end else begin
                    nxt.cnt = cur.cnt - DC_W'(1);
                end
            end
            default: nxt.st = IDLE;
        endcase

        if (rise) begin
            nxt.st  = HIGH;
            nxt.cnt = DC_W'(weff_q - WID_W'(1));
            nxt.idx = cur.idx + 8'd1;
            if (sel_q == EXT_SEL) nxt.ext_sent = cur.ext_sent + CNT_W'(1);
            else                  nxt.inj_sent = cur.inj_sent + CNT_W'(1);
        end
    end

    core_t vote;

    if (TMR != 0) begin : g_tmr
        core_t rep [3];
        always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
            if (RST_RESYNC) begin
                for (int i = 0; i < 3; i++) rep[i] <= '0;
            end else begin
                for (int i = 0; i < 3; i++) rep[i] <= nxt;
            end
        end
        cal_vote3 #(.W(CORE_W)) u_vote (
            .a (rep[0]),
            .b (rep[1]),
            .c (rep[2]),
            .y (vote)
        );
    end else begin : g_single
        core_t rep;
        always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
            if (RST_RESYNC) rep <= '0;
            else            rep <= nxt;
        end
        assign vote = rep;
    end

    assign cur      = vote;
    assign INJ_SENT = cur.inj_sent;
    assign EXT_SENT = cur.ext_sent;

    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            sel_q    <= INJ_SEL;
            weff_q   <= WID_W'(1);
            peff_q   <= (PER_W+1)'(2);
            npulse_q <= '0;
        end else if (cfg_ld) begin
            sel_q    <= SEL;
            weff_q   <= weff_in;
            peff_q   <= peff_in;
            npulse_q <= NPULSE;
        end
    end

    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            INJ_OUT <= 1'b0;
            EXT_OUT <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            INJ_OUT <= (nxt.st == HIGH) && (sel_q == INJ_SEL);
            EXT_OUT <= (nxt.st == HIGH) && (sel_q == EXT_SEL);
            BUSY    <= (nxt.st != IDLE);
            DONE    <= done_nxt;
        end
    end
endmodule

// File: tb/tb_cal_pulse_gen.sv
// Bench for cal_pulse_gen: TMR=0 and TMR=1 instances driven in lockstep against a timing model.
`timescale 1ns/1ps
module tb_cal_pulse_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, sel;
    logic [7:0]  delay;
    logic [3:0]  width;
    logic [11:0] period;
    logic [7:0]  npulse;

    logic        inj0, ext0, busy0, done0, inj1, ext1, busy1, done1;
    logic [11:0] isent0, esent0, isent1, esent1;

    int n_tot = 0;
    int n_bad = 0;

    // model state: t counts edges since the START-accept edge
    int m_d, m_w, m_p, m_n, t;
    bit m_sel, m_busy;
    int m_isent, m_esent;
    bit e_inj, e_ext, e_busy, e_done;

    always #5 clk = ~clk;

    cal_pulse_gen #(.TMR(0)) u_dut0 (
        .CLK40(clk), .RST_RESYNC(rst), .START(start), .ABORT(abort), .SEL(sel),
        .DELAY(delay), .WIDTH(width), .PERIOD(period), .NPULSE(npulse),
        .INJ_OUT(inj0), .EXT_OUT(ext0), .BUSY(busy0), .DONE(done0),
        .INJ_SENT(isent0), .EXT_SENT(esent0)
    );

    cal_pulse_gen #(.TMR(1)) u_dut1 (
        .CLK40(clk), .RST_RESYNC(rst), .START(start), .ABORT(abort), .SEL(sel),
        .DELAY(delay), .WIDTH(width), .PERIOD(period), .NPULSE(npulse),
        .INJ_OUT(inj1), .EXT_OUT(ext1), .BUSY(busy1), .DONE(done1),
        .INJ_SENT(isent1), .EXT_SENT(esent1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit st, input bit ab);
        int ph;
        e_inj  = 1'b0;
        e_ext  = 1'b0;
        e_done = 1'b0;
        if (!m_busy) begin
            if (st && !ab) begin
                m_sel  = sel;
                m_d    = delay;
                m_w    = (width == 0) ? 1 : width;
                m_p    = (period < m_w + 1) ? m_w + 1 : period;
                m_n    = npulse;
                t      = 0;
                m_busy = 1'b1;
            end
        end else if (ab) begin
            m_busy = 1'b0;
        end else begin
            t++;
            ph = t - m_d - 1;
            if (m_n != 0 && t == m_d + 1 + (m_n - 1) * m_p + m_w) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end else if (ph >= 0 && (ph % m_p) < m_w) begin
                if (m_sel) e_ext = 1'b1;
                else       e_inj = 1'b1;
                if (ph % m_p == 0) begin
                    if (m_sel) m_esent = (m_esent + 1) % 4096;
                    else       m_isent = (m_isent + 1) % 4096;
                end
            end
        end
        e_busy = m_busy;
    endtask

    task automatic check_all();
        chk("inj0", inj0, e_inj);      chk("inj1", inj1, e_inj);
        chk("ext0", ext0, e_ext);      chk("ext1", ext1, e_ext);
        chk("busy0", busy0, e_busy);   chk("busy1", busy1, e_busy);
        chk("done0", done0, e_done);   chk("done1", done1, e_done);
        chk("isent0", isent0, m_isent); chk("isent1", isent1, m_isent);
        chk("esent0", esent0, m_esent); chk("esent1", esent1, m_esent);
    endtask

    task automatic run_cycle(input bit st, input bit ab);
        start = st;
        abort = ab;
        @(posedge clk);
        #1;
        model_step(st, ab);
        check_all();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic set_cfg(input bit s, input int d, input int w, input int p, input int n);
        sel    = s;
        delay  = 8'(d);
        width  = 4'(w);
        period = 12'(p);
        npulse = 8'(n);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_isent = 0;
        m_esent = 0;
        e_inj   = 1'b0;
        e_ext   = 1'b0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
    endtask

    initial begin
        int done_at, nrise, prev, base, fall_seen;
        int rises[$];

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        t = 0;
        #20;
        check_all();
        #2 rst = 1'b0;

        // single injection pulse
        set_cfg(0, 3, 2, 10, 1);
        run_cycle(1'b1, 1'b0);
        done_at = -1;
        rises.delete();
        prev = 0;
        for (int e = 1; e <= 8; e++) begin
            if (e == 2) set_cfg(1, 0, 9, 3, 7);
            run_cycle(1'b0, 1'b0);
            if (done0) done_at = e;
            if (inj0 && !prev) rises.push_back(e);
            prev = inj0;
        end
        chk("t1_done_edge", done_at, 6);
        chk("t1_nrise", rises.size(), 1);
        if (rises.size() > 0) chk("t1_rise_edge", rises[0], 4);
        chk("t1_inj_sent", isent0, 1);
        chk("t1_ext_sent", esent0, 0);

        // external train
        set_cfg(1, 0, 1, 4, 5);
        run_cycle(1'b1, 1'b0);
        rises.delete();
        prev = 0;
        done_at = -1;
        for (int e = 1; e <= 22; e++) begin
            run_cycle(1'b0, 1'b0);
            if (ext0 && !prev) rises.push_back(e);
            prev = ext0;
            if (done0) done_at = e;
        end
        chk("t2_nrise", rises.size(), 5);
        foreach (rises[i]) chk("t2_rise_edge", rises[i], 1 + 4 * i);
        chk("t2_done_edge", done_at, 18);
        chk("t2_ext_sent", esent0, 5);

        // clamped width/period
        set_cfg(0, 0, 0, 1, 3);
        run_cycle(1'b1, 1'b0);
        rises.delete();
        prev = 0;
        nrise = 0;
        for (int e = 1; e <= 10; e++) begin
            run_cycle(1'b0, 1'b0);
            if (inj0 && !prev) rises.push_back(e);
            if (inj0) nrise++;
            prev = inj0;
        end
        chk("t3_nrise", rises.size(), 3);
        chk("t3_high_cycles", nrise, 3);
        for (int i = 1; i < rises.size(); i++) chk("t3_spacing", rises[i] - rises[i-1], 2);

        // continuous train aborted after seven pulses
        set_cfg(0, 1, 1, 3, 0);
        base = m_isent;
        fall_seen = 0;
        run_cycle(1'b1, 1'b0);
        for (int e = 0; e < 100 && m_isent - base < 7; e++) run_cycle(1'b0, 1'b0);
        chk("t4_reach7", m_isent - base, 7);
        run_cycle(1'b0, 1'b1);
        chk("t4_out_low", inj0, 0);
        chk("t4_busy_low", busy0, 0);
        for (int e = 0; e < 5; e++) begin
            run_cycle(1'b0, 1'b0);
            if (done0) fall_seen = 1;
        end
        chk("t4_no_done", fall_seen, 0);
        chk("t4_count", isent0 - base, 7);

        // START and ABORT together in IDLE
        set_cfg(1, 0, 1, 2, 1);
        run_cycle(1'b1, 1'b1);
        chk("t5_busy", busy0, 0);
        run_cycle(1'b0, 1'b0);
        chk("t5_ext", ext0, 0);

        // START while busy is dropped
        base = esent0;
        set_cfg(1, 4, 2, 5, 1);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b0, 1'b0);
        set_cfg(0, 0, 1, 2, 3);
        run_cycle(1'b1, 1'b0);
        for (int e = 0; e < 15; e++) run_cycle(1'b0, 1'b0);
        chk("t6_ext_delta", esent0 - base, 1);

        // reset while the injection line is high
        set_cfg(0, 2, 4, 8, 2);
        run_cycle(1'b1, 1'b0);
        for (int e = 0; e < 20 && !e_inj; e++) run_cycle(1'b0, 1'b0);
        chk("t7_inj_high", inj0, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t7_inj0", inj0, 0);     chk("t7_inj1", inj1, 0);
        chk("t7_busy0", busy0, 0);   chk("t7_busy1", busy1, 0);
        chk("t7_isent0", isent0, 0); chk("t7_isent1", isent1, 0);
        chk("t7_esent0", esent0, 0); chk("t7_esent1", esent1, 0);
        #2 rst = 1'b0;

        // 4096 single pulses wrap the sent counter
        set_cfg(0, 0, 1, 2, 1);
        for (int i = 0; i < 4096; i++) begin
            run_cycle(1'b1, 1'b0);
            run_cycle(1'b0, 1'b0);
            run_cycle(1'b0, 1'b0);
        end
        chk("t8_wrap0", isent0, 0);
        chk("t8_wrap1", isent1, 0);

        // random trains with occasional aborts and inputs changing mid-train
        for (int c = 0; c < 800; c++) begin
            set_cfg($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 8), $urandom_range(0, 4));
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
